rgb_led_arbiter: RTL and testbench

Shares the single RGB LED driver between several requesters (host firmware status, sensor activity, heartbeat). Arbitrates once per PWM frame with fixed priority, latches the winner's 24-bit colour, and generates glitch-free per-channel PWM enables for the RGB0PWM/RGB1PWM/RGB2PWM inputs of the RGB hard IP. It sits between the clock/reset block and the LED driver instance in the top level.

---
 rtl/rgb_led_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rgb_led_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares one RGB LED driver between NUM_REQ requesters.
// Arbitration happens once per PWM frame, at the frame's last cycle. The
// lowest asserted index wins, and its colour and blink bits are latched for
// the whole next frame. The block drives per-channel PWM enables for
// RGB0PWM/RGB1PWM/RGB2PWM.
//
// Optional feature: define RGB_LED_ARBITER_BLINK_EN to build the frame-based
// blink counter and gating. When it is undefined, blink and BLINK_FRAMES are
// ignored.
//
// Ports:
//   clk        system clock (48 MHz)
//   reset      asynchronous, active-high reset
//   req        level request per requester (index 0 = highest priority)
//   color      per requester {red, green, blue} duty, requester i at
//              [i*3*PWM_BITS +: 3*PWM_BITS]
//   blink      per requester blink enable
//   gnt        one-hot (or zero) current owner
//   pwm_r/g/b  PWM enables to the RGB hard IP
//   frame_tick one-cycle pulse, coincident with the per-frame gnt update
module rgb_led_arbiter #(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned BLINK_FRAMES = 8192
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*3*PWM_BITS-1:0] color,
   input  logic [NUM_REQ-1:0]            blink,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          pwm_r,
   output logic                          pwm_g,
   output logic                          pwm_b,
   output logic                          frame_tick
);

   localparam int unsigned COLOR_W = 3 * PWM_BITS;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [NUM_REQ-1:0]    gnt_d;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [PWM_BITS-1:0]   active_r;
   logic [PWM_BITS-1:0]   active_g;
   logic [PWM_BITS-1:0]   active_b;
   logic [PWM_BITS-1:0]   active_r_d;
   logic [PWM_BITS-1:0]   active_g_d;
   logic [PWM_BITS-1:0]   active_b_d;
   logic                  frame_end;
   logic                  blink_gate;
`ifdef RGB_LED_ARBITER_BLINK_EN
   logic                  active_blink;
   logic                  active_blink_d;
`endif

   assign frame_end = (pwm_cnt == {PWM_BITS{1'b1}});

   // Ownership next-state: frozen mid-frame, re-arbitrated at frame_end.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt;
      active_r_d = active_r;
      active_g_d = active_g;
      active_b_d = active_b;
`ifdef RGB_LED_ARBITER_BLINK_EN
      active_blink_d = active_blink;
`endif
      if (frame_end) begin
         state_d    = IDLE;
         gnt_d      = '0;
         active_r_d = '0;
         active_g_d = '0;
         active_b_d = '0;
`ifdef RGB_LED_ARBITER_BLINK_EN
         active_blink_d = 1'b0;
`endif
         // Scan downwards so that the lowest asserted index is the final writer.
         for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
               state_d = OWNED;
               gnt_d   = NUM_REQ'(1) << i;
               {active_r_d, active_g_d, active_b_d} = color[i*COLOR_W +: COLOR_W];
`ifdef RGB_LED_ARBITER_BLINK_EN
               active_blink_d = blink[i];
`endif
            end
         end
      end
   end

   // State, latched duties, frame counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt        <= '0;
         active_r   <= '0;
         active_g   <= '0;
         active_b   <= '0;
         pwm_cnt    <= '0;
         pwm_r      <= 1'b0;
         pwm_g      <= 1'b0;
         pwm_b      <= 1'b0;
         frame_tick <= 1'b0;
`ifdef RGB_LED_ARBITER_BLINK_EN
         active_blink <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gnt        <= gnt_d;
         active_r   <= active_r_d;
         active_g   <= active_g_d;
         active_b   <= active_b_d;
         pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
         // The compare uses the current count, so pwm lags pwm_cnt by one cycle.
         pwm_r      <= (pwm_cnt < active_r) && blink_gate;
         pwm_g      <= (pwm_cnt < active_g) && blink_gate;
         pwm_b      <= (pwm_cnt < active_b) && blink_gate;
         frame_tick <= frame_end;
`ifdef RGB_LED_ARBITER_BLINK_EN
         active_blink <= active_blink_d;
`endif
      end
   end

`ifdef RGB_LED_ARBITER_BLINK_EN
   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   // Free-running frame counter, so owner changes never restart the blink phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (frame_end) begin
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   assign blink_gate = !active_blink || blink_phase;
`else
   logic unused_blink;

   assign blink_gate   = 1'b1;
   assign unused_blink = ^{blink, 32'(BLINK_FRAMES)};
`endif

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Testbench for rgb_led_arbiter (NUM_REQ=3, PWM_BITS=8, BLINK_FRAMES=2).
// It combines a table of per-frame vectors, directed multi-cycle sequences
// and a randomized phase, which is checked against a frame-level model.
module tb_rgb_led_arbiter;

   localparam int FRAME = 256;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [71:0] color;
   logic [2:0]  blink;
   logic [2:0]  gnt;
   logic        pwm_r;
   logic        pwm_g;
   logic        pwm_b;
   logic        frame_tick;

   rgb_led_arbiter #(
      .NUM_REQ      (3),
      .PWM_BITS     (8),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .color      (color),
      .blink      (blink),
      .gnt        (gnt),
      .pwm_r      (pwm_r),
      .pwm_g      (pwm_g),
      .pwm_b      (pwm_b),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit model_chk = 1'b0;

   // Frame-level reference model. Frame position is kept as an integer; blink
   // phase is derived from the number of completed frames.
   int         m_cnt;
   int         m_owner;
   int         m_frames;
   int         m_duty [3];
   bit         m_blink;
   bit         m_fe;
   bit         m_gate;
   logic [2:0] e_gnt;
   bit         e_r, e_g, e_b, e_tick;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt = 0; m_owner = -1; m_frames = 0; m_blink = 1'b0; m_fe = 1'b0;
         m_duty[0] = 0; m_duty[1] = 0; m_duty[2] = 0;
         e_gnt = 3'b000; e_r = 1'b0; e_g = 1'b0; e_b = 1'b0; e_tick = 1'b0;
      end else begin
`ifdef RGB_LED_ARBITER_BLINK_EN
         m_gate = !m_blink || (((m_frames / 2) % 2) == 0);
`else
         m_gate = 1'b1;
`endif
         e_r    = (m_cnt < m_duty[0]) && m_gate;
         e_g    = (m_cnt < m_duty[1]) && m_gate;
         e_b    = (m_cnt < m_duty[2]) && m_gate;
         e_tick = (m_cnt == FRAME - 1);
         m_fe   = e_tick;
         if (m_fe) begin
            m_frames++;
            m_owner = -1;
            for (int i = 2; i >= 0; i--) if (req[i]) m_owner = i;
            if (m_owner >= 0) begin
               m_duty[0] = int'(color[m_owner*24+16 +: 8]);
               m_duty[1] = int'(color[m_owner*24+8 +: 8]);
               m_duty[2] = int'(color[m_owner*24 +: 8]);
               m_blink   = blink[m_owner];
            end else begin
               m_duty[0] = 0; m_duty[1] = 0; m_duty[2] = 0; m_blink = 1'b0;
            end
         end
         m_cnt = (m_cnt + 1) % FRAME;
         e_gnt = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (model_chk) begin
         chk("model_gnt", int'(gnt), int'(e_gnt));
         chk("model_pwm_r", int'(pwm_r), int'(e_r));
         chk("model_pwm_g", int'(pwm_g), int'(e_g));
         chk("model_pwm_b", int'(pwm_b), int'(e_b));
         chk("model_frame_tick", int'(frame_tick), int'(e_tick));
      end
   endtask

   // Advance up to and including the next frame-end edge, as seen by the bench's own frame timing.
   task automatic wait_frame_edge();
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (!m_fe && k < 300);
      if (!m_fe) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame_edge_timeout: got none expected one within 300 cycles");
      end
   endtask

   // Count the high cycles of each channel over one frame and any gnt deviations.
   task automatic measure_frame(input logic [2:0] exp_gnt, output int r, output int g,
                                output int b, output int gnt_dev);
      r = 0; g = 0; b = 0; gnt_dev = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         r += int'(pwm_r);
         g += int'(pwm_g);
         b += int'(pwm_b);
         if (i < FRAME - 1 && gnt != exp_gnt) gnt_dev++;
      end
   endtask

   typedef struct {
      logic [2:0]  req;
      logic [71:0] color;
      logic [2:0]  exp_gnt;
      int          exp_r;
      int          exp_g;
      int          exp_b;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int r, g, b, dev, ticks, bad_pos, any_pwm, gnt_nz, on_frames, exp_on;

      vecs[0] = '{3'b000, {24'h333333, 24'h222222, 24'h111111}, 3'b000, 0, 0, 0};
      vecs[1] = '{3'b101, {24'hFF0102, 24'h000000, 24'h102030}, 3'b001, 16, 32, 48};
      vecs[2] = '{3'b010, {24'h000000, 24'h8000FF, 24'h000000}, 3'b010, 128, 0, 255};
      vecs[3] = '{3'b100, {24'hFF0100, 24'h000000, 24'h000000}, 3'b100, 255, 1, 0};
      vecs[4] = '{3'b110, {24'h050505, 24'h0A0B0C, 24'h000000}, 3'b010, 10, 11, 12};
      vecs[5] = '{3'b111, {24'hFFFFFF, 24'h777777, 24'h010203}, 3'b001, 1, 2, 3};

      reset = 1'b0; req = '0; color = '0; blink = '0;
      #2 reset = 1'b1;
      #1;
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
      chk("reset_frame_tick", int'(frame_tick), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle for three frames: ticks every 256 cycles, nothing lit.
      ticks = 0; bad_pos = 0; any_pwm = 0; gnt_nz = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (frame_tick) begin
            ticks++;
            if ((i % FRAME) != FRAME - 1) bad_pos++;
         end
         if (pwm_r || pwm_g || pwm_b) any_pwm++;
         if (gnt != 3'b000) gnt_nz++;
      end
      chk("idle_tick_count", ticks, 3);
      chk("idle_tick_position", bad_pos, 0);
      chk("idle_pwm", any_pwm, 0);
      chk("idle_gnt", gnt_nz, 0);

      // Table: inputs latched at the next frame end, then one frame measured.
      foreach (vecs[v]) begin
         req = vecs[v].req; color = vecs[v].color; blink = '0;
         wait_frame_edge();
         chk($sformatf("vec%0d_gnt", v), int'(gnt), int'(vecs[v].exp_gnt));
         chk($sformatf("vec%0d_tick", v), int'(frame_tick), 1);
         measure_frame(vecs[v].exp_gnt, r, g, b, dev);
         chk($sformatf("vec%0d_r_cycles", v), r, vecs[v].exp_r);
         chk($sformatf("vec%0d_g_cycles", v), g, vecs[v].exp_g);
         chk($sformatf("vec%0d_b_cycles", v), b, vecs[v].exp_b);
         chk($sformatf("vec%0d_gnt_stable", v), dev, 0);
      end

      // No mid-frame pre-emption; colour changes wait for the boundary.
      req = 3'b100; color = {24'h400000, 24'h000000, 24'h000000};
      wait_frame_edge();
      chk("pre_gnt_owner2", int'(gnt), 4);
      r = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         r += int'(pwm_r);
         if (i == 99) begin
            req = 3'b101; color = {24'hFF0000, 24'h000000, 24'hC0FFEE};
         end
         if (i == FRAME - 2) chk("pre_gnt_hold", int'(gnt), 4);
      end
      chk("pre_frozen_r_cycles", r, 64);
      chk("pre_gnt_switch", int'(gnt), 1);
      chk("pre_switch_tick", int'(frame_tick), 1);
      measure_frame(3'b001, r, g, b, dev);
      chk("pre_new_r", r, 8'hC0);
      chk("pre_new_g", g, 8'hFF);
      chk("pre_new_b", b, 8'hEE);
      req = 3'b100;
      wait_frame_edge();
      chk("drop_req0_gnt", int'(gnt), 4);

      // Blink: over any four frames, two are lit when blink gating exists.
      model_chk = 1'b1;
      req = 3'b001; color = {24'h000000, 24'h000000, 24'hFF0000}; blink = 3'b001;
      wait_frame_edge();
`ifdef RGB_LED_ARBITER_BLINK_EN
      exp_on = 2;
`else
      exp_on = 4;
`endif
      on_frames = 0;
      repeat (4) begin
         measure_frame(3'b001, r, g, b, dev);
         if (r == 255) on_frames++;
         else if (r != 0) chk("blink_frame_r_cycles", r, 255);
      end
      chk("blink_on_frames", on_frames, exp_on);
      blink = 3'b000;
      wait_frame_edge();
      on_frames = 0;
      repeat (4) begin
         measure_frame(3'b001, r, g, b, dev);
         if (r == 255) on_frames++;
      end
      chk("noblink_on_frames", on_frames, 4);
      model_chk = 1'b0;

      // Reset mid-frame while owned: immediate clear, first frame is full length.
      repeat (100) tick();
      chk("pre_reset_pwm_r", int'(pwm_r), 1);
      chk("pre_reset_gnt", int'(gnt), 1);
      reset = 1'b1;
      #1;
      chk("async_reset_gnt", int'(gnt), 0);
      chk("async_reset_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
      chk("async_reset_tick", int'(frame_tick), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      ticks = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         if (i < FRAME - 1 && frame_tick) ticks++;
         if (i == FRAME - 2) chk("post_reset_gnt_idle", int'(gnt), 0);
      end
      chk("post_reset_early_ticks", ticks, 0);
      chk("post_reset_gnt", int'(gnt), 1);
      chk("post_reset_tick", int'(frame_tick), 1);

      // Randomized traffic against the model.
      model_chk = 1'b1;
      repeat (6 * FRAME) begin
         if ($urandom_range(0, 63) == 0) begin
            req   = 3'($urandom);
            color = 72'({$urandom, $urandom, $urandom});
            blink = 3'($urandom);
         end
         tick();
      end
      model_chk = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
